// File: rtl/axi_wr_arbiter_if.sv
// Requester/arbiter/write-master signal bundle for axi_wr_arbiter.
// slave: the arbiter side; master: the side driving requests and the B channel.
interface axi_wr_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic               wr_en;
    logic [31:0]        wr_addr;
    logic [31:0]        wr_data;
    logic               bvalid;
    logic               bready;
    logic [1:0]         bresp;
    logic               busy;

    modport slave (
        input  req, req_addr, req_data, bvalid, bready, bresp,
        output gnt, done, err, wr_en, wr_addr, wr_data, busy
    );

    modport master (
        output req, req_addr, req_data, bvalid, bready, bresp,
        input  gnt, done, err, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter feeding one AXI-lite write master, one transaction at a time.
// Optional response timeout with drain state: define AXIW_ARB_TIMEOUT_EN.
module axi_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned TO_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    axi_wr_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1) begin : g_param_check
        $error("axi_wr_arbiter: NREQ must be 2..8 and TO_CYCLES >= 1");
    end

`ifdef AXIW_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TO_CYCLES + 1);
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;
`else
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
`endif

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [IdxW-1:0]   cur_q, cur_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
`ifdef AXIW_ARB_TIMEOUT_EN
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              to_q, to_d;
`endif

    logic              win_found;
    logic [IdxW-1:0]   win_idx;
    logic [31:0]       win_addr;
    logic [31:0]       win_data;
    int unsigned       cand;
    logic              bfire;

    assign bfire = bus.bvalid && bus.bready;

    // Search upward from the requester after the last one served.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        win_data  = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(last_q) + 1 + i) % NREQ;
            if (!win_found && bus.req[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
                win_addr  = bus.req_addr[cand*32 +: 32];
                win_data  = bus.req_data[cand*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cur_d   = cur_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef AXIW_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    cur_d   = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                    addr_d  = win_addr;
                    data_d  = win_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                err_d   = 1'b0;
`ifdef AXIW_ARB_TIMEOUT_EN
                cnt_d   = '0;
                to_d    = 1'b0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (bfire) begin
                    err_d   = (bus.bresp != 2'b00);
                    state_d = StDone;
`ifdef AXIW_ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TO_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                gnt_d   = '0;
                last_d  = cur_q;
                err_d   = 1'b0;
`ifdef AXIW_ARB_TIMEOUT_EN
                // The late response still has to be absorbed before re-arbitrating.
                state_d = to_q ? StDrain : StIdle;
`else
                state_d = StIdle;
`endif
            end
`ifdef AXIW_ARB_TIMEOUT_EN
            StDrain: begin
                if (bfire) begin
                    to_d    = 1'b0;
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= IdxW'(NREQ - 1);
            cur_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef AXIW_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef AXIW_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = (state_q == StDone) ? gnt_q : '0;
    assign bus.err     = (state_q == StDone) && err_q;
    assign bus.wr_en   = (state_q == StIssue);
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign bus.busy    = (state_q != StIdle);
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (NREQ=4, TO_CYCLES=16).
// All stimulus and sampling happen 1 time unit after the rising edge.
module tb_axi_wr_arbiter;
    localparam int unsigned NREQ = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    axi_wr_arbiter_if #(.NREQ(NREQ)) bus ();

    axi_wr_arbiter #(.NREQ(NREQ), .TO_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.bvalid   = 1'b0;
        bus.bready   = 1'b0;
        bus.bresp    = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({bus.gnt, bus.done, bus.err, bus.wr_en, bus.busy} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {bus.gnt, bus.done, bus.err, bus.wr_en, bus.busy});
        end
        n_cmp++;
        if ({bus.wr_addr, bus.wr_data} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h want 0", {bus.wr_addr, bus.wr_data});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req_addr[63:32] = 32'h0000_1000;
        bus.req_data[63:32] = 32'hA5A5_A5A5;
        bus.req             = 4'b0010;
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b1 || bus.gnt !== 4'b0010 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_issue: got wr_en=%b gnt=%b busy=%b want 1 0010 1",
                     bus.wr_en, bus.gnt, bus.busy);
        end
        n_cmp++;
        if (bus.wr_addr !== 32'h0000_1000 || bus.wr_data !== 32'hA5A5_A5A5) begin
            n_bad++;
            $display("FAIL single_addr_data: got %h %h want 00001000 a5a5a5a5",
                     bus.wr_addr, bus.wr_data);
        end
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b0 || bus.gnt !== 4'b0010 || bus.done !== 4'b0) begin
            n_bad++;
            $display("FAIL single_wait: got wr_en=%b gnt=%b done=%b want 0 0010 0000",
                     bus.wr_en, bus.gnt, bus.done);
        end
        tick();
        tick();
        bus.bvalid = 1'b1;
        bus.bready = 1'b1;
        bus.bresp  = 2'b00;
        tick();
        n_cmp++;
        if (bus.done !== 4'b0010 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got done=%b err=%b want 0010 0", bus.done, bus.err);
        end
        bus.bvalid = 1'b0;
        bus.bready = 1'b0;
        bus.req    = '0;
        tick();
        n_cmp++;
        if (bus.done !== 4'b0 || bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle: got done=%b gnt=%b busy=%b want 0 0 0",
                     bus.done, bus.gnt, bus.busy);
        end
        n_cmp++;
        if (bus.wr_addr !== 32'h0000_1000) begin
            n_bad++;
            $display("FAIL single_addr_hold: got %h want 00001000", bus.wr_addr);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int         n_done;
        n_done = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[i*32 +: 32] = 32'h2000 + 32'(i) * 32'h10;
            bus.req_data[i*32 +: 32] = 32'hD000 + 32'(i);
        end
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            for (int n = 0; n < 8 && bus.wr_en !== 1'b1; n++) tick();
            n_cmp++;
            if (bus.wr_en !== 1'b1) begin
                n_bad++;
                $display("FAIL rr_wr_en_wait[%0d]: got %b want 1", k, bus.wr_en);
            end
            n_cmp++;
            if (bus.gnt !== exp_gnt || bus.wr_addr !== 32'h2000 + 32'(k % 4) * 32'h10) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got gnt=%b addr=%h want %b %h", k, bus.gnt,
                         bus.wr_addr, exp_gnt, 32'h2000 + 32'(k % 4) * 32'h10);
            end
            tick();
            bus.bvalid = 1'b1;
            bus.bready = 1'b1;
            tick();
            if (bus.done !== 4'b0) n_done++;
            n_cmp++;
            if (bus.done !== exp_gnt) begin
                n_bad++;
                $display("FAIL rr_done[%0d]: got %b want %b", k, bus.done, exp_gnt);
            end
            bus.bvalid = 1'b0;
            bus.bready = 1'b0;
            tick();
            n_cmp++;
            if (bus.done !== 4'b0 || bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
                n_bad++;
                $display("FAIL rr_idle_gap[%0d]: got done=%b busy=%b gnt=%b want 0 0 0",
                         k, bus.done, bus.busy, bus.gnt);
            end
        end
        bus.req = '0;
        n_cmp++;
        if (n_done != 5) begin
            n_bad++;
            $display("FAIL rr_done_count: got %0d want 5", n_done);
        end
        tick();
    endtask

    task automatic test_error();
        do_reset();
        bus.req_addr[95:64] = 32'h0000_3000;
        bus.req             = 4'b0100;
        tick();
        tick();
        bus.bvalid = 1'b1;
        bus.bready = 1'b1;
        bus.bresp  = 2'b10;
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_in_wait: got %b want 0", bus.err);
        end
        tick();
        n_cmp++;
        if (bus.err !== 1'b1 || bus.done !== 4'b0100) begin
            n_bad++;
            $display("FAIL err_done: got err=%b done=%b want 1 0100", bus.err, bus.done);
        end
        bus.bvalid = 1'b0;
        bus.bready = 1'b0;
        bus.bresp  = 2'b00;
        bus.req    = '0;
        tick();
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_after_done: got %b want 0", bus.err);
        end
    endtask

    task automatic test_drop();
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        bus.req = '0;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_hold: got gnt=%b busy=%b want 0010 1", bus.gnt, bus.busy);
        end
        bus.bvalid = 1'b1;
        bus.bready = 1'b1;
        tick();
        n_cmp++;
        if (bus.done !== 4'b0010) begin
            n_bad++;
            $display("FAIL drop_done: got %b want 0010", bus.done);
        end
        bus.bvalid = 1'b0;
        bus.bready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_addr[127:96] = 32'h0000_4000;
        bus.req              = 4'b0001;
        tick();
        tick();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_busy: got %b want 1", bus.busy);
        end
        rst_n   = 1'b0;
        bus.req = '0;
        tick();
        n_cmp++;
        if ({bus.gnt, bus.done, bus.err, bus.wr_en, bus.busy, bus.wr_addr, bus.wr_data}
            !== 75'b0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: gnt=%b done=%b err=%b wr_en=%b busy=%b want 0",
                     bus.gnt, bus.done, bus.err, bus.wr_en, bus.busy);
        end
        rst_n   = 1'b1;
        bus.req = 4'b1000;
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b1 || bus.gnt !== 4'b1000 || bus.wr_addr !== 32'h0000_4000) begin
            n_bad++;
            $display("FAIL rstmid_regrant: got wr_en=%b gnt=%b addr=%h want 1 1000 00004000",
                     bus.wr_en, bus.gnt, bus.wr_addr);
        end
        tick();
        bus.bvalid = 1'b1;
        bus.bready = 1'b1;
        tick();
        n_cmp++;
        if (bus.done !== 4'b1000) begin
            n_bad++;
            $display("FAIL rstmid_done: got %b want 1000", bus.done);
        end
        bus.bvalid = 1'b0;
        bus.bready = 1'b0;
        bus.req    = '0;
        tick();
    endtask

`ifdef AXIW_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.req = 4'b0001;
        tick();
        for (int w = 0; w < 16; w++) begin
            tick();
            n_cmp++;
            if (bus.done !== 4'b0 || bus.busy !== 1'b1) begin
                n_bad++;
                $display("FAIL to_wait[%0d]: got done=%b busy=%b want 0000 1",
                         w, bus.done, bus.busy);
            end
        end
        tick();
        n_cmp++;
        if (bus.done !== 4'b0001 || bus.err !== 1'b1) begin
            n_bad++;
            $display("FAIL to_done: got done=%b err=%b want 0001 1", bus.done, bus.err);
        end
        bus.req = '0;
        tick();
        n_cmp++;
        if (bus.gnt !== 4'b0 || bus.busy !== 1'b1 || bus.done !== 4'b0) begin
            n_bad++;
            $display("FAIL to_drain: got gnt=%b busy=%b done=%b want 0 1 0",
                     bus.gnt, bus.busy, bus.done);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL to_drain_hold: got %b want 1", bus.busy);
        end
        bus.bvalid = 1'b1;
        bus.bready = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL to_drain_exit: got %b want 0", bus.busy);
        end
        bus.bvalid = 1'b0;
        bus.bready = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.bvalid   = 1'b0;
        bus.bready   = 1'b0;
        bus.bresp    = 2'b00;
        test_reset();
        test_single();
        test_round_robin();
        test_error();
        test_drop();
        test_reset_mid();
`ifdef AXIW_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
